// File: rtl/noc_vc_stream_bridge.sv
// noc_vc_stream_bridge: NUM_VC NoC ingress FIFOs merged onto one Avalon-ST
// source with packet-locked round-robin; one ack flit per packet. Option: NOC_BRIDGE_STATS_EN.
module noc_vc_stream_bridge #(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH  = 600,
  parameter int NUM_VC     = 2,
  parameter int NOC_RADIX  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACK_DEPTH  = 4,
  localparam int EMPTY_W = $clog2(DATA_WIDTH/8),
  localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int DST_W   = $clog2(NOC_RADIX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NOC_WIDTH-1:0] i_data_in,
  input  logic                 i_valid_in,
  output logic [NUM_VC-1:0]    i_ready_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [VC_W-1:0]      out_channel,
  input  logic [DST_W-1:0]     i_reply_dst,
  output logic [NOC_WIDTH-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in
`ifdef NOC_BRIDGE_STATS_EN
  ,
  output logic [31:0]          o_pkt_count,
  output logic [31:0]          o_drop_count,
  output logic [31:0]          o_stall_cycles
`endif
);

  localparam int O_EMP  = DATA_WIDTH;
  localparam int O_DST  = O_EMP + EMPTY_W;
  localparam int O_VC   = O_DST + DST_W;
  localparam int O_TAIL = O_VC + VC_W;
  localparam int O_HEAD = O_TAIL + 1;
  localparam int FW     = DATA_WIDTH + EMPTY_W + 2;
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int AA_W   = $clog2(ACK_DEPTH);
  localparam int AKW    = DST_W + VC_W + 32;

  if (NOC_WIDTH < DATA_WIDTH + EMPTY_W + DST_W + VC_W + 2) begin : g_bad_width
    $error("NOC_WIDTH too small for flit fields");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            r_state;
  logic [VC_W-1:0]   r_lock_vc;
  logic [VC_W-1:0]   r_ptr;
  logic [15:0]       r_beats;
  logic [15:0]       r_seq [NUM_VC];

  logic [FW-1:0]     r_mem [NUM_VC][FIFO_DEPTH];
  logic [FA_W:0]     r_wp [NUM_VC];
  logic [FA_W:0]     r_rp [NUM_VC];
  logic [AKW-1:0]    r_amem [ACK_DEPTH];
  logic [AA_W:0]     r_awp;
  logic [AA_W:0]     r_arp;

  logic [NUM_VC-1:0] w_full, w_ne, w_push, w_pop;
  logic [VC_W-1:0]   w_in_vc;
  logic              w_in_ok;
  logic [FW-1:0]     w_in_flit;
  logic              w_unused;
  logic [VC_W-1:0]   w_rr_vc;
  logic              w_rr_hit;
  int                w_rr_idx;
  logic [VC_W-1:0]   w_sel;
  logic [VC_W-1:0]   w_next_ptr;
  logic              w_sel_ne;
  logic [FW-1:0]     w_hd;
  logic              w_xfer, w_tail, w_head;
  logic [15:0]       w_cnt;
  logic              w_afull, w_ane, w_apush, w_apop;
  logic [AKW-1:0]    w_aq;

  assign w_in_vc   = i_data_in[O_VC +: VC_W];
  assign w_in_ok   = {1'b0, w_in_vc} < (VC_W+1)'(NUM_VC);
  assign w_in_flit = {i_data_in[O_HEAD], i_data_in[O_TAIL],
                      i_data_in[O_EMP +: EMPTY_W], i_data_in[DATA_WIDTH-1:0]};
  assign w_unused  = ^i_data_in;

  // per-VC FIFO status and push/pop strobes
  always_comb begin
    w_ne   = '0;
    w_full = '0;
    w_push = '0;
    w_pop  = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_ne[k]   = (r_wp[k] != r_rp[k]);
      w_full[k] = (r_wp[k][FA_W] != r_rp[k][FA_W]) &&
                  (r_wp[k][FA_W-1:0] == r_rp[k][FA_W-1:0]);
      w_push[k] = i_valid_in && w_in_ok && !w_full[k] &&
                  (w_in_vc == VC_W'(k));
      w_pop[k]  = w_xfer && (w_sel == VC_W'(k));
    end
  end

  assign i_ready_out = ~w_full;

  // round-robin pick: first non-empty VC at or after the pointer
  always_comb begin
    w_rr_vc  = r_ptr;
    w_rr_hit = 1'b0;
    w_rr_idx = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_rr_idx = int'(r_ptr) + i;
      if (w_rr_idx >= NUM_VC) w_rr_idx = w_rr_idx - NUM_VC;
      if (!w_rr_hit && w_ne[w_rr_idx]) begin
        w_rr_vc  = VC_W'(w_rr_idx);
        w_rr_hit = 1'b1;
      end
    end
  end

  assign w_sel      = (r_state == S_LOCKED) ? r_lock_vc : w_rr_vc;
  assign w_next_ptr = (w_sel == VC_W'(NUM_VC-1)) ? '0 : w_sel + VC_W'(1);
  assign w_sel_ne   = w_ne[w_sel] && !reset;
  assign w_hd       = r_mem[w_sel][r_rp[w_sel][FA_W-1:0]];
  assign w_tail     = w_hd[FW-2];
  assign w_head     = w_hd[FW-1];
  assign w_cnt      = (&r_beats) ? r_beats : r_beats + 16'd1;

  assign w_afull = (r_awp[AA_W] != r_arp[AA_W]) &&
                   (r_awp[AA_W-1:0] == r_arp[AA_W-1:0]);
  assign w_ane   = (r_awp != r_arp) && !reset;
  assign w_aq    = r_amem[r_arp[AA_W-1:0]];

  assign out_valid   = w_sel_ne && !w_afull;
  assign w_xfer      = out_valid && out_ready;
  assign w_apush     = w_xfer && w_tail;
  assign w_apop      = w_ane && o_ready_in;
  assign out_data    = w_sel_ne ? w_hd[DATA_WIDTH-1:0] : '0;
  assign out_sop     = w_sel_ne && w_head;
  assign out_eop     = w_sel_ne && w_tail;
  assign out_empty   = (w_sel_ne && w_tail) ? w_hd[O_EMP +: EMPTY_W] : '0;
  assign out_channel = w_sel_ne ? w_sel : '0;
  assign o_valid_out = w_ane;

  // ack flit assembly from the reply FIFO head
  always_comb begin
    o_data_out = '0;
    if (w_ane) begin
      o_data_out[31:0]             = w_aq[31:0];
      o_data_out[O_VC +: VC_W]     = w_aq[32 +: VC_W];
      o_data_out[O_DST +: DST_W]   = w_aq[AKW-1 -: DST_W];
      o_data_out[O_TAIL]           = 1'b1;
      o_data_out[O_HEAD]           = 1'b1;
    end
  end

  // ingress FIFO storage
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++)
      if (w_push[k]) r_mem[k][r_wp[k][FA_W-1:0]] <= w_in_flit;
  end

  // ingress FIFO pointers
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++) begin
      if (reset) begin
        r_wp[k] <= '0;
        r_rp[k] <= '0;
      end else begin
        if (w_push[k]) r_wp[k] <= r_wp[k] + 1'b1;
        if (w_pop[k])  r_rp[k] <= r_rp[k] + 1'b1;
      end
    end
  end

  // arbiter lock, round-robin pointer and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lock_vc <= '0;
      r_ptr     <= '0;
      r_beats   <= '0;
    end else if (w_xfer) begin
      if (w_tail) begin
        r_state <= S_IDLE;
        r_ptr   <= w_next_ptr;
        r_beats <= '0;
      end else begin
        r_state   <= S_LOCKED;
        r_lock_vc <= w_sel;
        r_beats   <= w_cnt;
      end
    end
  end

  // per-VC packet sequence numbers
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++) begin
      if (reset)                                r_seq[k] <= '0;
      else if (w_apush && w_sel == VC_W'(k))   r_seq[k] <= r_seq[k] + 16'd1;
    end
  end

  // reply FIFO storage
  always_ff @(posedge clk) begin
    if (w_apush)
      r_amem[r_awp[AA_W-1:0]] <= {i_reply_dst, w_sel, r_seq[w_sel], w_cnt};
  end

  // reply FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_awp <= '0;
      r_arp <= '0;
    end else begin
      if (w_apush) r_awp <= r_awp + 1'b1;
      if (w_apop)  r_arp <= r_arp + 1'b1;
    end
  end

`ifdef NOC_BRIDGE_STATS_EN
  logic w_stall;
  assign w_stall = w_sel_ne && w_afull;

  // delivery, drop and back-pressure counters
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pkt_count    <= '0;
      o_drop_count   <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (w_apush)                 o_pkt_count    <= o_pkt_count + 32'd1;
      if (i_valid_in && !w_in_ok)  o_drop_count   <= o_drop_count + 32'd1;
      if (w_stall)                 o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
